mult_div_unit: RTL and testbench

//  Sequential signed multiply/divide responder for the multicycle MIPS core.
//  The control unit initiates an operation with a one-cycle MultCtrl or DivCtrl

---
 rtl/mult_div_unit_pkg.sv | 11 +
 rtl/mult_div_unit_div_core.sv | 62 ++++++
 rtl/mult_div_unit.sv | 130 +++++++++++++
 tb/tb_mult_div_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared constants for the sequential multiply/divide unit
package mult_div_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// rtl/mult_div_unit_div_core.sv - restoring divide on magnitudes with sign fix-up
// quotient/remainder are the fixed-up results of the step taken on the current edge.
module mult_div_unit_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   dvs;
  logic [WIDTH-1:0] quo;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    if (!trial[WIDTH+1]) begin
      rem_nx = trial[WIDTH:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quotient  = neg_q ? -quo_nx : quo_nx;
    remainder = neg_r ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem   <= '0;
      dvs   <= '0;
      quo   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      rem   <= '0;
      quo   <= a[WIDTH-1] ? -a : a;
      // Divisor magnitude kept one bit wider so 0x80000000 stays positive.
      dvs   <= b[WIDTH-1] ? -{b[WIDTH-1], b} : {1'b0, b};
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
    end else if (step) begin
      rem <= rem_nx;
      quo <= quo_nx;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed MULT/DIV responder (Booth multiply, restoring divide)
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int ITERS = WIDTH;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] mcand;
  logic             qm1;

  logic             last;
  logic             div_load;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] mplr_nx;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  assign last     = (cnt == CNT_W'(ITERS - 1));
  assign div_load = (state == ST_IDLE) && !MultCtrl && DivCtrl && (B != '0);

  // Booth add/sub done one bit wider so a most-negative multiplicand cannot overflow.
  always_comb begin
    case ({mplr[0], qm1})
      2'b01:   booth_sum = {acc[WIDTH-1], acc} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {acc[WIDTH-1], acc} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {acc[WIDTH-1], acc};
    endcase
    acc_nx  = booth_sum[WIDTH:1];
    mplr_nx = {booth_sum[0], mplr[WIDTH-1:1]};
  end

  mult_div_unit_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clock     (clock),
    .reset     (reset),
    .load      (div_load),
    .step      (state == ST_DIV),
    .a         (A),
    .b         (B),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      mplr    <= '0;
      mcand   <= '0;
      qm1     <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (MultCtrl) begin
            mcand <= A;
            mplr  <= B;
            acc   <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            state <= ST_MULT;
            Busy  <= 1'b1;
          end else if (DivCtrl) begin
            if (B == '0) begin
              DivZero <= 1'b1;
            end else begin
              cnt   <= '0;
              state <= ST_DIV;
              Busy  <= 1'b1;
            end
          end
        end
        ST_MULT: begin
          acc  <= acc_nx;
          mplr <= mplr_nx;
          qm1  <= mplr[0];
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            HI    <= acc_nx;
            LO    <= mplr_nx;
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_DIV: begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            HI    <= div_r;
            LO    <= div_q;
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        mult_ctrl;
  logic        div_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks;
  int fails;

  mult_div_unit dut (
    .clock    (clock),
    .reset    (reset),
    .MultCtrl (mult_ctrl),
    .DivCtrl  (div_ctrl),
    .A        (a),
    .B        (b),
    .HI       (hi),
    .LO       (lo),
    .Busy     (busy),
    .Done     (done),
    .DivZero  (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic start_op(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clock);
    mult_ctrl = m;
    div_ctrl  = d;
    a         = av;
    b         = bv;
    @(posedge clock);
    #1;
    mult_ctrl = 1'b0;
    div_ctrl  = 1'b0;
    a         = $urandom;
    b         = $urandom;
  endtask

  // n = sampled cycles with Done low before Done is seen; nb = those with Busy high
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (n < 100) begin
      @(negedge clock);
      if (done) break;
      if (busy) nb++;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL reset_hilo got %h expected 0", {hi, lo}); end
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b expected 000", {busy, done, div_zero}); end
  endtask

  task automatic test_mult_basic;
    int n, nb;
    start_op(1'b1, 1'b0, 32'd3, 32'hFFFFFFFE);
    wait_done(n, nb);
    checks++;
    if (n !== 32) begin fails++; $display("FAIL mult_basic_latency got %0d expected 32", n); end
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin fails++; $display("FAIL mult_basic_result got %h expected ffffffff_fffffffa", {hi, lo}); end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL mult_done_width got %b expected 0", done); end
  endtask

  task automatic test_mult_max;
    int n, nb;
    start_op(1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    wait_done(n, nb);
    checks++;
    if (nb !== 32) begin fails++; $display("FAIL mult_max_busy got %0d expected 32", nb); end
    checks++;
    if ({hi, lo} !== 64'h3FFFFFFF_00000001) begin fails++; $display("FAIL mult_max_result got %h expected 3fffffff_00000001", {hi, lo}); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL mult_max_busy_end got %b expected 0", busy); end
    start_op(1'b1, 1'b0, 32'h80000000, 32'h80000000);
    wait_done(n, nb);
    checks++;
    if ({hi, lo} !== 64'h40000000_00000000) begin fails++; $display("FAIL mult_minneg_result got %h expected 40000000_00000000", {hi, lo}); end
  endtask

  task automatic test_div_signs;
    int n, nb;
    start_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE);
    wait_done(n, nb);
    checks++;
    if (n !== 32) begin fails++; $display("FAIL div_latency got %0d expected 32", n); end
    checks++;
    if ({hi, lo} !== {32'd1, 32'hFFFFFFFD}) begin fails++; $display("FAIL div_7_m2 got %h expected 00000001_fffffffd", {hi, lo}); end
    start_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done(n, nb);
    checks++;
    if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin fails++; $display("FAIL div_m7_2 got %h expected ffffffff_fffffffd", {hi, lo}); end
    start_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE);
    wait_done(n, nb);
    checks++;
    if ({hi, lo} !== {32'hFFFFFFFF, 32'd3}) begin fails++; $display("FAIL div_m7_m2 got %h expected ffffffff_00000003", {hi, lo}); end
  endtask

  task automatic test_div_zero;
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    @(negedge clock);
    checks++;
    if ({div_zero, busy, done} !== 3'b100) begin fails++; $display("FAIL divzero_flags got %b expected 100", {div_zero, busy, done}); end
    checks++;
    if ({hi, lo} !== {32'hFFFFFFFF, 32'd3}) begin fails++; $display("FAIL divzero_hold got %h expected ffffffff_00000003", {hi, lo}); end
    @(negedge clock);
    checks++;
    if ({div_zero, busy} !== 2'b00) begin fails++; $display("FAIL divzero_width got %b expected 00", {div_zero, busy}); end
  endtask

  task automatic test_mult_repulse;
    int n, nb;
    start_op(1'b1, 1'b0, 32'd3, 32'd5);
    repeat (4) @(negedge clock);
    mult_ctrl = 1'b1;
    div_ctrl  = 1'b1;
    a         = 32'd100;
    b         = 32'd100;
    @(posedge clock);
    #1;
    mult_ctrl = 1'b0;
    div_ctrl  = 1'b0;
    wait_done(n, nb);
    checks++;
    if (n !== 28) begin fails++; $display("FAIL repulse_latency got %0d expected 28", n); end
    checks++;
    if ({hi, lo} !== 64'd15) begin fails++; $display("FAIL repulse_result got %h expected 15", {hi, lo}); end
  endtask

  task automatic test_reset_mid_div;
    int n, nb, seen;
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({hi, lo, busy} !== 65'd0) begin fails++; $display("FAIL midreset_state got %h expected 0", {hi, lo, busy}); end
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin fails++; $display("FAIL midreset_done got %0d pulses expected 0", seen); end
    start_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n, nb);
    checks++;
    if ({hi, lo} !== {32'd0, 32'h80000000}) begin fails++; $display("FAIL div_overflow got %h expected 00000000_80000000", {hi, lo}); end
  endtask

  task automatic test_back_to_back;
    int n, nb;
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    wait_done(n, nb);
    checks++;
    if ({hi, lo} !== 64'd42) begin fails++; $display("FAIL b2b_first got %h expected 42", {hi, lo}); end
    mult_ctrl = 1'b1;
    a         = 32'hFFFFFFFD;
    b         = 32'd5;
    @(posedge clock);
    #1;
    mult_ctrl = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, done} !== 2'b10) begin fails++; $display("FAIL b2b_accept got %b expected 10", {busy, done}); end
    wait_done(n, nb);
    checks++;
    if (n !== 31) begin fails++; $display("FAIL b2b_latency got %0d expected 31", n); end
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin fails++; $display("FAIL b2b_second got %h expected ffffffff_fffffff1", {hi, lo}); end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    reset     = 1'b1;
    mult_ctrl = 1'b0;
    div_ctrl  = 1'b0;
    a         = '0;
    b         = '0;
    test_reset;
    test_mult_basic;
    test_mult_max;
    test_div_signs;
    test_div_zero;
    test_mult_repulse;
    test_reset_mid_div;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
